avatar_election_ctrl: RTL and testbench

- Parametrised successor of the lab avatar-selection voter: timed registration phase, then timed voting phase, then results.
- Generalised in candidate count, user-ID width, ballot-box count and phase lengths.
- Adds an explicit start/restart, an invalid-candidate check, per-candidate tally query and a result-valid flag.
- Sits between the user-input decoder and the display/result logic of the election lab top level.

---
 rtl/avatar_pkg.sv | 33 +++
 rtl/avatar_election_ctrl_if.sv | 43 ++++
 rtl/avatar_election_ctrl_argmax.sv | 22 ++
 rtl/avatar_election_ctrl.sv | 170 +++++++++++++++++
 tb/tb_avatar_election_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/avatar_pkg.sv
// Shared types and constants for the avatar election controller.
package avatar_pkg;

    typedef enum logic [1:0] {
        PH_IDLE = 2'b00,
        PH_REG  = 2'b01,
        PH_VOTE = 2'b10,
        PH_DONE = 2'b11
    } phase_t;

    typedef enum logic [1:0] {
        OP_NOP      = 2'b00,
        OP_REGISTER = 2'b01,
        OP_VOTE     = 2'b10,
        OP_QUERY    = 2'b11
    } mode_t;

    // Bit positions of the one-cycle error pulses inside the error vector
    localparam int ERR_ALREADY_REG      = 0;
    localparam int ERR_ALREADY_VOTED    = 1;
    localparam int ERR_NOT_REG          = 2;
    localparam int ERR_VOTE_NOT_STARTED = 3;
    localparam int ERR_REG_ENDED        = 4;
    localparam int ERR_VOTE_ENDED       = 5;
    localparam int ERR_INVALID_CAND     = 6;
    localparam int NUM_ERR              = 7;

    // Candidate index width, never narrower than one bit
    function automatic int cand_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/avatar_election_ctrl_if.sv
// Command/response bundle between the input decoder and the election controller.
interface avatar_election_ctrl_if
    import avatar_pkg::*;
#(
    parameter int ID_W     = 6,
    parameter int NUM_CAND = 4,
    parameter int BOX_W    = 2
);
    localparam int CAND_W = cand_w(NUM_CAND);
    localparam int CNT_W  = ID_W + 1;

    logic              start;
    logic [1:0]        mode;
    logic [ID_W-1:0]   user_id;
    logic [CAND_W-1:0] candidate;

    phase_t            phase;
    logic [BOX_W-1:0]  ballot_box_id;
    logic [CNT_W-1:0]  num_registered;
    logic [CNT_W-1:0]  query_count;
    logic [CAND_W-1:0] winner_id;
    logic [CNT_W-1:0]  winner_votes;
    logic              result_valid;
    logic              already_registered, already_voted, not_registered;
    logic              voting_not_started, registration_ended, voting_ended;
    logic              invalid_candidate;

    modport master (
        output start, mode, user_id, candidate,
        input  phase, ballot_box_id, num_registered, query_count, winner_id,
               winner_votes, result_valid, already_registered, already_voted,
               not_registered, voting_not_started, registration_ended,
               voting_ended, invalid_candidate
    );

    modport slave (
        input  start, mode, user_id, candidate,
        output phase, ballot_box_id, num_registered, query_count, winner_id,
               winner_votes, result_valid, already_registered, already_voted,
               not_registered, voting_not_started, registration_ended,
               voting_ended, invalid_candidate
    );
endinterface

// File: rtl/avatar_election_ctrl_argmax.sv
// Combinational argmax over candidate tallies; ties go to the lowest index.
module election_argmax #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 7,
    parameter int CAND_W   = 2
) (
    input  logic [NUM_CAND-1:0][CNT_W-1:0] tally,
    output logic [CAND_W-1:0]              idx,
    output logic [CNT_W-1:0]               max_cnt
);
    // Strict greater-than keeps the earlier (lower) index on ties
    always_comb begin
        idx     = '0;
        max_cnt = tally[0];
        for (int i = 1; i < NUM_CAND; i++) begin
            if (tally[i] > max_cnt) begin
                idx     = CAND_W'(i);
                max_cnt = tally[i];
            end
        end
    end
endmodule

// File: rtl/avatar_election_ctrl.sv
// Timed registration/voting controller with tallies, query port and leader tracking.
module avatar_election_ctrl
    import avatar_pkg::*;
#(
    parameter int ID_W        = 6,
    parameter int NUM_CAND    = 4,
    parameter int BOX_W       = 2,
    parameter int REG_CYCLES  = 100,
    parameter int VOTE_CYCLES = 100
) (
    input logic                   CLK,
    input logic                   RST_N,
    avatar_election_ctrl_if.slave bus
);
    localparam int CAND_W    = cand_w(NUM_CAND);
    localparam int CNT_W     = ID_W + 1;
    localparam int NUM_USERS = 1 << ID_W;
    localparam int PH_MAX    = (REG_CYCLES > VOTE_CYCLES) ? REG_CYCLES : VOTE_CYCLES;
    localparam int PCNT_W    = $clog2(PH_MAX + 1);

    phase_t                        phase_q, phase_d;
    logic [PCNT_W-1:0]             pcnt_q, pcnt_d;
    logic [NUM_USERS-1:0]          reg_q, voted_q;
    logic [NUM_CAND-1:0][CNT_W-1:0] tally_q;
    logic [CNT_W-1:0]              nreg_q, qcnt_q, wvotes_q, max_w;
    logic [CAND_W-1:0]             wid_q, idx_w;
    logic [BOX_W-1:0]              box_q;
    logic [NUM_ERR-1:0]            err_q, err_d;
    logic                          do_reg, do_vote, cand_ok, start_ok;
    mode_t                         op;

    assign op       = mode_t'(bus.mode);
    assign start_ok = bus.start && (phase_q == PH_IDLE || phase_q == PH_DONE);
    assign cand_ok  = int'(bus.candidate) < NUM_CAND;

    // Phase state and in-phase cycle counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase_q <= PH_IDLE;
            pcnt_q  <= '0;
        end else begin
            phase_q <= phase_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // Phase sequencing: start only from IDLE/DONE, timed REG and VOTE windows
    always_comb begin
        phase_d = phase_q;
        pcnt_d  = pcnt_q;
        case (phase_q)
            PH_IDLE, PH_DONE: begin
                if (bus.start) begin
                    phase_d = PH_REG;
                    pcnt_d  = '0;
                end
            end
            PH_REG: begin
                if (pcnt_q == PCNT_W'(REG_CYCLES - 1)) begin
                    phase_d = PH_VOTE;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            PH_VOTE: begin
                if (pcnt_q == PCNT_W'(VOTE_CYCLES - 1)) begin
                    phase_d = PH_DONE;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Op legality against the pre-edge phase; at most one error bit per op
    always_comb begin
        err_d   = '0;
        do_reg  = 1'b0;
        do_vote = 1'b0;
        case (op)
            OP_REGISTER: begin
                case (phase_q)
                    PH_REG: begin
                        if (reg_q[bus.user_id]) err_d[ERR_ALREADY_REG] = 1'b1;
                        else                    do_reg = 1'b1;
                    end
                    PH_IDLE: err_d[ERR_VOTE_NOT_STARTED] = 1'b1;
                    default: err_d[ERR_REG_ENDED]        = 1'b1;
                endcase
            end
            OP_VOTE: begin
                if (phase_q == PH_IDLE || phase_q == PH_REG) err_d[ERR_VOTE_NOT_STARTED] = 1'b1;
                else if (phase_q == PH_DONE)                 err_d[ERR_VOTE_ENDED]       = 1'b1;
                else if (!reg_q[bus.user_id])                err_d[ERR_NOT_REG]          = 1'b1;
                else if (voted_q[bus.user_id])               err_d[ERR_ALREADY_VOTED]    = 1'b1;
                else if (!cand_ok)                           err_d[ERR_INVALID_CAND]     = 1'b1;
                else                                         do_vote = 1'b1;
            end
            default: ;
        endcase
    end

    election_argmax #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W),
        .CAND_W   (CAND_W)
    ) u_argmax (
        .tally   (tally_q),
        .idx     (idx_w),
        .max_cnt (max_w)
    );

    // Voter tables, tallies and registered outputs; a start clears the election last so it wins
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            reg_q    <= '0;
            voted_q  <= '0;
            tally_q  <= '0;
            nreg_q   <= '0;
            qcnt_q   <= '0;
            wid_q    <= '0;
            wvotes_q <= '0;
            box_q    <= '0;
            err_q    <= '0;
        end else begin
            err_q    <= err_d;
            wid_q    <= idx_w;
            wvotes_q <= max_w;
            if (op == OP_REGISTER || op == OP_VOTE)
                box_q <= bus.user_id[ID_W-1 -: BOX_W];
            if (op == OP_QUERY)
                qcnt_q <= cand_ok ? tally_q[bus.candidate] : '0;
            if (do_reg) begin
                reg_q[bus.user_id] <= 1'b1;
                nreg_q             <= nreg_q + 1'b1;
            end
            if (do_vote) begin
                voted_q[bus.user_id]   <= 1'b1;
                tally_q[bus.candidate] <= tally_q[bus.candidate] + 1'b1;
            end
            if (start_ok) begin
                reg_q    <= '0;
                voted_q  <= '0;
                tally_q  <= '0;
                nreg_q   <= '0;
                wid_q    <= '0;
                wvotes_q <= '0;
            end
        end
    end

    assign bus.phase              = phase_q;
    assign bus.result_valid       = (phase_q == PH_DONE);
    assign bus.ballot_box_id      = box_q;
    assign bus.num_registered     = nreg_q;
    assign bus.query_count        = qcnt_q;
    assign bus.winner_id          = wid_q;
    assign bus.winner_votes       = wvotes_q;
    assign bus.already_registered = err_q[ERR_ALREADY_REG];
    assign bus.already_voted      = err_q[ERR_ALREADY_VOTED];
    assign bus.not_registered     = err_q[ERR_NOT_REG];
    assign bus.voting_not_started = err_q[ERR_VOTE_NOT_STARTED];
    assign bus.registration_ended = err_q[ERR_REG_ENDED];
    assign bus.voting_ended       = err_q[ERR_VOTE_ENDED];
    assign bus.invalid_candidate  = err_q[ERR_INVALID_CAND];

endmodule

// File: tb/tb_avatar_election_ctrl.sv
// Directed bench for avatar_election_ctrl with hand-computed expectations.
module tb_avatar_election_ctrl;
    import avatar_pkg::*;

    localparam int ID_W  = 6;
    localparam int NC    = 3;
    localparam int BW    = 2;
    localparam int RC    = 20;
    localparam int VC    = 30;
    localparam int CW    = cand_w(NC);

    // Expected error vectors, order {areg, avoted, nreg, vns, rend, vend, inv}
    localparam logic [6:0] E_NONE = 7'b0000000;
    localparam logic [6:0] E_AREG = 7'b1000000;
    localparam logic [6:0] E_AVOT = 7'b0100000;
    localparam logic [6:0] E_NREG = 7'b0010000;
    localparam logic [6:0] E_VNS  = 7'b0001000;
    localparam logic [6:0] E_REND = 7'b0000100;
    localparam logic [6:0] E_VEND = 7'b0000010;
    localparam logic [6:0] E_INV  = 7'b0000001;

    logic CLK = 1'b0;
    logic RST_N;
    int   total = 0;
    int   bad   = 0;
    int   ec    = 0;

    avatar_election_ctrl_if #(.ID_W(ID_W), .NUM_CAND(NC), .BOX_W(BW)) bus ();

    avatar_election_ctrl #(
        .ID_W(ID_W), .NUM_CAND(NC), .BOX_W(BW), .REG_CYCLES(RC), .VOTE_CYCLES(VC)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] errv();
        return {bus.already_registered, bus.already_voted, bus.not_registered,
                bus.voting_not_started, bus.registration_ended, bus.voting_ended,
                bus.invalid_candidate};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        ec++;
    endtask

    // Apply one op for one edge, then return the bus to NOP
    task automatic op(input logic [1:0] m, input int id, input int c);
        bus.mode      = m;
        bus.user_id   = ID_W'(id);
        bus.candidate = CW'(c);
        tick();
        bus.mode = 2'b00;
    endtask

    initial begin
        RST_N = 1'b0;
        bus.start = 1'b0; bus.mode = 2'b00; bus.user_id = '0; bus.candidate = '0;
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (5) tick();
        chk("idle_phase", bus.phase, 0);
        chk("idle_box", bus.ballot_box_id, 0);
        chk("idle_nreg", bus.num_registered, 0);
        chk("idle_qcnt", bus.query_count, 0);
        chk("idle_win", {bus.winner_id, bus.winner_votes}, 0);
        chk("idle_rv", bus.result_valid, 0);
        chk("idle_err", errv(), E_NONE);

        // ---- run A ----
        bus.start = 1'b1; tick(); bus.start = 1'b0; ec = 0;
        chk("startA_phase", bus.phase, 1);
        op(2'b01, 5, 0);
        chk("reg5_nreg", bus.num_registered, 1);
        chk("reg5_err", errv(), E_NONE);
        op(2'b01, 5, 0);
        chk("reg5b_err", errv(), E_AREG);
        chk("reg5b_nreg", bus.num_registered, 1);
        chk("reg5b_box", bus.ballot_box_id, 0);
        op(2'b01, 63, 0);
        chk("reg63_box", bus.ballot_box_id, 3);
        chk("reg63_nreg", bus.num_registered, 2);
        chk("reg63_err", errv(), E_NONE);
        op(2'b10, 5, 0);
        chk("vote_in_reg", errv(), E_VNS);
        for (int i = 10; i <= 16; i++) op(2'b01, i, 0);
        chk("reg_many_nreg", bus.num_registered, 9);
        while (ec < RC - 1) tick();
        chk("reg_last_phase", bus.phase, 1);
        tick();
        chk("vote_phase", bus.phase, 2);

        op(2'b01, 20, 0);
        chk("reg_in_vote", errv(), E_REND);
        chk("reg_in_vote_box", bus.ballot_box_id, 1);
        op(2'b10, 9, 0);
        chk("unreg_vote", errv(), E_NREG);
        op(2'b10, 5, 2);
        chk("vote5_err", errv(), E_NONE);
        op(2'b10, 5, 2);
        chk("vote5b_err", errv(), E_AVOT);
        op(2'b11, 0, 2);
        chk("query2", bus.query_count, 1);
        op(2'b10, 16, 3);
        chk("inv_cand", errv(), E_INV);
        op(2'b11, 0, 3);
        chk("query_oob", bus.query_count, 0);
        op(2'b10, 10, 1); op(2'b10, 11, 1); op(2'b10, 12, 1);
        op(2'b10, 13, 2); op(2'b10, 14, 2);
        tick();
        chk("tie_id", bus.winner_id, 1);
        chk("tie_votes", bus.winner_votes, 3);
        op(2'b10, 15, 2);
        chk("lag_id", bus.winner_id, 1);
        tick();
        chk("lead2_id", bus.winner_id, 2);
        chk("lead2_votes", bus.winner_votes, 4);
        op(2'b11, 0, 1);
        chk("query1", bus.query_count, 3);
        op(2'b11, 0, 0);
        chk("query0", bus.query_count, 0);
        while (ec < RC + VC - 1) tick();
        chk("vote_last_phase", bus.phase, 2);
        chk("vote_last_rv", bus.result_valid, 0);
        tick();
        chk("done_phase", bus.phase, 3);
        chk("done_rv", bus.result_valid, 1);
        op(2'b10, 10, 1);
        chk("vote_in_done", errv(), E_VEND);
        op(2'b01, 63, 0);
        chk("reg_in_done", errv(), E_REND);
        chk("reg_in_done_box", bus.ballot_box_id, 3);
        chk("done_win", {bus.winner_id, bus.winner_votes}, {2'd2, 7'd4});
        chk("done_nreg", bus.num_registered, 9);

        // ---- run B: restart from DONE with a same-cycle REGISTER ----
        bus.start = 1'b1; op(2'b01, 5, 0); bus.start = 1'b0; ec = 0;
        chk("restart_phase", bus.phase, 1);
        chk("restart_err", errv(), E_REND);
        chk("restart_nreg", bus.num_registered, 0);
        chk("restart_win", {bus.winner_id, bus.winner_votes}, 0);
        chk("restart_box", bus.ballot_box_id, 0);
        op(2'b01, 5, 0);
        chk("rereg5_err", errv(), E_NONE);
        chk("rereg5_nreg", bus.num_registered, 1);
        op(2'b11, 0, 2);
        chk("query2_cleared", bus.query_count, 0);
        op(2'b01, 63, 0);
        chk("rereg63_nreg", bus.num_registered, 2);
        while (ec < RC) tick();
        chk("B_vote_phase", bus.phase, 2);
        op(2'b10, 5, 0);
        chk("B_vote_err", errv(), E_NONE);
        op(2'b11, 0, 0);
        chk("B_query0", bus.query_count, 1);
        chk("B_win_votes", bus.winner_votes, 1);

        // ---- asynchronous reset mid-VOTE ----
        RST_N = 1'b0;
        #2;
        chk("rst_phase", bus.phase, 0);
        chk("rst_nreg", bus.num_registered, 0);
        chk("rst_qcnt", bus.query_count, 0);
        chk("rst_win", {bus.winner_id, bus.winner_votes}, 0);
        chk("rst_rv", bus.result_valid, 0);
        chk("rst_err", errv(), E_NONE);
        tick();
        RST_N = 1'b1;
        repeat (3) tick();
        chk("post_rst_phase", bus.phase, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
